// File: rtl/oven_display_seq.sv
// Oven display sequencer: periodic snapshot -> min/sec split -> double dabble -> atomic commit to six 7-seg digits.
// Optional macro OVEN_DISP_LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens of temperature fields.
module oven_display_seq #(
    parameter int TEMP_W      = 10,
    parameter int TIME_W      = 13,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic              tempInputDone,
    input  logic              timeInputDone,
    input  logic [TEMP_W-1:0] current_temp,
    input  logic [TEMP_W-1:0] target_temp,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] target_time,
    output logic [0:6]        hex0,
    output logic [0:6]        hex1,
    output logic [0:6]        hex2,
    output logic [0:6]        hex3,
    output logic [0:6]        hex4,
    output logic [0:6]        hex5,
    output logic              busy
);
    localparam int TW  = (TEMP_W > 10) ? TEMP_W : 10;
    localparam int RW  = (TIME_W > 7) ? TIME_W : 7;
    localparam int RCW = $clog2(REFRESH_DIV);
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    typedef enum logic [2:0] {IDLE, SNAP, SPLIT, BCD, COMMIT} state_t;
    typedef enum logic [1:0] {M_OFF, M_TSET, M_MSET, M_RUN} mode_t;

    function automatic mode_t decode_mode(input logic pwr, input logic tdone, input logic mdone);
        if (!pwr)   return M_OFF;
        if (!tdone) return M_TSET;
        if (!mdone) return M_MSET;
        return M_RUN;
    endfunction

    function automatic logic [9:0] sat999(input logic [TW-1:0] v);
        if (v > TW'(999)) return 10'd999;
        return v[9:0];
    endfunction

    // {bcd[11:0], bin[9:0]}: add 3 to any BCD nibble >= 5, then shift left one bit
    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        logic [21:0] r;
        r = s;
        for (int n = 0; n < 3; n++)
            if (r[10+4*n +: 4] >= 4'd5) r[10+4*n +: 4] = r[10+4*n +: 4] + 4'd3;
        return {r[20:0], 1'b0};
    endfunction

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [20:0] temp_field(input logic [11:0] b);
        logic [0:6] h, t, o;
        h = seg7(b[11:8]);
        t = seg7(b[7:4]);
        o = seg7(b[3:0]);
`ifdef OVEN_DISP_LEADING_ZERO_BLANK_EN
        if (b[11:8] == 4'd0) begin
            h = SEG_BLANK;
            if (b[7:4] == 4'd0) t = SEG_BLANK;
        end
`endif
        return {h, t, o};
    endfunction

    state_t            state;
    mode_t             mode_q, in_mode;
    logic [RCW-1:0]    refresh_cnt;
    logic [BCW-1:0]    blink_cnt;
    logic              blink_ph, refresh_tick, split_done;
    logic [3:0]        bit_cnt;
    logic [TEMP_W-1:0] ct_q, tt_q;
    logic [RW-1:0]     rem;
    logic [6:0]        mins;
    logic [5:0]        secs;
    logic [21:0]       dd_hi, dd_lo;
    logic [20:0]       hi_seg, lo_seg;
    logic [5:0][0:6]   disp_q, new_disp, disp_sel, gated;
    logic [5:0]        mask_q, new_mask, mask_sel;

    assign in_mode      = decode_mode(power, tempInputDone, timeInputDone);
    assign refresh_tick = (refresh_cnt == RCW'(REFRESH_DIV - 1));
    assign split_done   = (mode_q == M_TSET) || (mode_q == M_RUN) || (mins == 7'd99) || (rem < RW'(60));
    assign secs         = (rem < RW'(60)) ? rem[5:0] : 6'd59;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b0;
        end else begin
            refresh_cnt <= refresh_tick ? '0 : refresh_cnt + 1'b1;
            if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mode_q  <= M_OFF;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE:   if (refresh_tick) begin state <= SNAP; busy <= 1'b1; end
                SNAP:   begin mode_q <= in_mode; state <= SPLIT; end
                SPLIT:  if (split_done) begin state <= BCD; bit_cnt <= '0; end
                BCD: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) state <= COMMIT;
                end
                COMMIT: begin state <= IDLE; busy <= 1'b0; end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: snapshot, repeated subtract-60 split, then ten parallel dabble steps
    always_ff @(posedge clk) begin
        case (state)
            SNAP: begin
                ct_q <= current_temp;
                tt_q <= target_temp;
                rem  <= (in_mode == M_MSET) ? RW'(target_time) : RW'(current_time);
                mins <= '0;
            end
            SPLIT: begin
                if (!split_done) begin
                    rem  <= rem - RW'(60);
                    mins <= mins + 7'd1;
                end else begin
                    case (mode_q)
                        M_RUN: begin
                            dd_hi <= {12'd0, sat999(TW'(tt_q))};
                            dd_lo <= {12'd0, sat999(TW'(ct_q))};
                        end
                        M_TSET: begin
                            dd_hi <= '0;
                            dd_lo <= {12'd0, sat999(TW'(tt_q))};
                        end
                        default: begin
                            dd_hi <= {15'd0, mins};
                            dd_lo <= {16'd0, secs};
                        end
                    endcase
                end
            end
            BCD: begin
                dd_hi <= dabble_step(dd_hi);
                dd_lo <= dabble_step(dd_lo);
            end
            default: ;
        endcase
    end

    always_comb begin
        new_disp = {6{SEG_BLANK}};
        new_mask = '0;
        hi_seg   = temp_field(dd_hi[21:10]);
        lo_seg   = temp_field(dd_lo[21:10]);
        case (mode_q)
            M_RUN: begin
                new_disp[5:3] = hi_seg;
                new_disp[2:0] = lo_seg;
            end
            M_TSET: begin
                new_disp[2:0] = lo_seg;
                new_mask      = 6'b000111;
            end
            default: begin
                new_disp[4] = seg7(dd_hi[17:14]);
                new_disp[3] = seg7(dd_hi[13:10]);
                new_disp[2] = SEG_DASH;
                new_disp[1] = seg7(dd_lo[17:14]);
                new_disp[0] = seg7(dd_lo[13:10]);
                if (mode_q == M_MSET) new_mask = 6'b011011;
            end
        endcase
    end

    // Commit bypasses the held copy so all six digits change on the same edge
    always_comb begin
        disp_sel = (state == COMMIT) ? new_disp : disp_q;
        mask_sel = (state == COMMIT) ? new_mask : mask_q;
        for (int k = 0; k < 6; k++)
            gated[k] = (blink_ph && mask_sel[k]) ? SEG_BLANK : disp_sel[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= {6{SEG_BLANK}};
            mask_q <= '0;
            {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{SEG_BLANK}};
        end else begin
            if (state == COMMIT) begin
                disp_q <= new_disp;
                mask_q <= new_mask;
            end
            {hex5, hex4, hex3, hex2, hex1, hex0} <= gated;
        end
    end
endmodule

// File: tb/tb_oven_display_seq.sv
// Scoreboard bench for oven_display_seq: driver queues expected displays, monitor checks each completed pass.
`timescale 1ns/1ps
module tb_oven_display_seq;
    localparam int TEMP_W = 10, TIME_W = 13, REFRESH_DIV = 256, BLINK_DIV = 1000;
    localparam int BL = 10, DS = 11;
`ifdef OVEN_DISP_LEADING_ZERO_BLANK_EN
    localparam int LZ = BL;
`else
    localparam int LZ = 0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic power = 1'b0, tempInputDone = 1'b0, timeInputDone = 1'b0;
    logic [TEMP_W-1:0] current_temp = '0, target_temp = '0;
    logic [TIME_W-1:0] current_time = '0, target_time = '0;
    logic [0:6] hex0, hex1, hex2, hex3, hex4, hex5;
    logic busy;

    always #5 clk = ~clk;

    oven_display_seq #(.TEMP_W(TEMP_W), .TIME_W(TIME_W), .REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .power(power), .tempInputDone(tempInputDone), .timeInputDone(timeInputDone),
        .current_temp(current_temp), .target_temp(target_temp), .current_time(current_time), .target_time(target_time),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5), .busy(busy)
    );

    typedef struct packed { logic [41:0] dig; logic [5:0] mask; } exp_t;
    exp_t exp_q[$];
    exp_t hold_exp;
    logic hold_en = 1'b0, prev_busy = 1'b0;
    int n_chk = 0, n_fail = 0, pass_cnt = 0, tb_cyc = 0, busy_len = 0;
    localparam logic [41:0] ALLB = {42{1'b1}};

    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            DS: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int d5, input int d4, input int d3, input int d2, input int d1, input int d0);
        return {seg(d5), seg(d4), seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    // Displayed value after the edge counted by tb_cyc uses the blink phase held before that edge
    function automatic logic [41:0] gate(input exp_t e);
        logic [41:0] r;
        logic ph;
        r  = e.dig;
        ph = (((tb_cyc - 1) / BLINK_DIV) % 2) == 1;
        for (int k = 0; k < 6; k++)
            if (ph && e.mask[k]) r[k*7 +: 7] = 7'b1111111;
        return r;
    endfunction

    function automatic logic [41:0] act();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic check(input string name, input logic [41:0] got, input logic [41:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, expv, tb_cyc);
        end
    endtask

    task automatic push(input logic [41:0] d, input logic [5:0] m);
        exp_t e;
        e.dig  = d;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic p, input logic td, input logic md, input int ct, input int tt, input int cti, input int tti);
        power         = p;
        tempInputDone = td;
        timeInputDone = md;
        current_temp  = TEMP_W'(ct);
        target_temp   = TEMP_W'(tt);
        current_time  = TIME_W'(cti);
        target_time   = TIME_W'(tti);
    endtask

    task automatic wait_until(input int target);
        int cyc = 0;
        while (pass_cnt < target && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (pass_cnt < target) begin
            n_fail++;
            $display("FAIL pass_timeout: completed %0d passes, required %0d", pass_cnt, target);
        end
    endtask

    task automatic wait_busy_rise();
        int cyc = 0;
        while (busy !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise_timeout: busy %b after %0d cycles, required 1", busy, cyc);
        end
    endtask

    // Monitor: one scoreboard pop per completed pass, plus steady-display checks while hold_en is set
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                n_chk++;
                if (busy_len > 200 || busy_len == 0) begin
                    n_fail++;
                    $display("FAIL busy_length: got %0d cycles, required 1..200", busy_len);
                end
                if (exp_q.size() > 0) check("pass_display", act(), gate(exp_q.pop_front()));
                pass_cnt++;
                busy_len = 0;
            end
            if (hold_en) check("hold_display", act(), gate(hold_exp));
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nb;
        repeat (5) @(negedge clk);
        check("reset_hex", act(), ALLB);
        check("reset_busy", {41'd0, busy}, 42'd0);

        // OFF 754 s = 12:34; first pass must start exactly at the first refresh tick
        set_in(1'b0, 1'b0, 1'b0, 0, 0, 754, 0);
        push(disp(BL, 1, 2, DS, 3, 4), 6'b0);
        reset = 1'b0;
        wait_busy_rise();
        check("first_tick", 42'(tb_cyc), 42'(REFRESH_DIV));
        wait_until(1);

        set_in(1'b0, 1'b0, 1'b0, 0, 0, 60, 0);
        push(disp(BL, 0, 1, DS, 0, 0), 6'b0);
        wait_until(pass_cnt + 1);

        set_in(1'b0, 1'b0, 1'b0, 0, 0, 6000, 0);
        push(disp(BL, 9, 9, DS, 5, 9), 6'b0);
        wait_until(pass_cnt + 1);

        set_in(1'b1, 1'b1, 1'b1, 75, 350, 0, 0);
        push(disp(3, 5, 0, LZ, 7, 5), 6'b0);
        wait_until(pass_cnt + 1);

        set_in(1'b1, 1'b1, 1'b1, 5, 1000, 0, 0);
        push(disp(9, 9, 9, LZ, LZ, 5), 6'b0);
        wait_until(pass_cnt + 1);

        set_in(1'b1, 1'b1, 1'b1, 1023, 0, 0, 0);
        push(disp(LZ, LZ, 0, 9, 9, 9), 6'b0);
        wait_until(pass_cnt + 1);

        set_in(1'b1, 1'b0, 1'b0, 0, 200, 0, 0);
        push(disp(BL, BL, BL, 2, 0, 0), 6'b000111);
        wait_until(pass_cnt + 1);

        // MSET 8191 s saturates to 99-59; digits blink, dash stays
        set_in(1'b1, 1'b1, 1'b0, 0, 0, 0, 8191);
        push(disp(BL, 9, 9, DS, 5, 9), 6'b011011);
        wait_until(pass_cnt + 1);
        hold_exp.dig  = disp(BL, 9, 9, DS, 5, 9);
        hold_exp.mask = 6'b011011;
        hold_en = 1'b1;
        nb = 0;
        for (int i = 0; i < 2 * BLINK_DIV; i++) begin
            @(negedge clk);
            if (hex4 === 7'b1111111) nb++;
        end
        hold_en = 1'b0;
        check("blink_blank_cycles", 42'(nb), 42'(BLINK_DIV));
        wait_until(pass_cnt + 1);

        // target_temp changes in the cycle after SNAP: this pass keeps 200, the next shows 450
        set_in(1'b1, 1'b1, 1'b1, 75, 200, 0, 0);
        push(disp(2, 0, 0, LZ, 7, 5), 6'b0);
        push(disp(4, 5, 0, LZ, 7, 5), 6'b0);
        base = pass_cnt;
        wait_busy_rise();
        @(posedge clk);
        #1 target_temp = TEMP_W'(450);
        wait_until(base + 2);

        // Reset in the middle of BCD aborts the pass and blanks immediately
        set_in(1'b0, 1'b0, 1'b0, 0, 0, 754, 0);
        push(disp(BL, 1, 2, DS, 3, 4), 6'b0);
        wait_until(pass_cnt + 1);
        wait_busy_rise();
        repeat (17) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_hex", act(), ALLB);
        check("async_reset_busy", {41'd0, busy}, 42'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("no_commit_after_abort", act(), ALLB);
        push(disp(BL, 1, 2, DS, 3, 4), 6'b0);
        base = pass_cnt;
        wait_busy_rise();
        check("first_tick_after_reset", 42'(tb_cyc), 42'(REFRESH_DIV));
        wait_until(base + 1);

        check("scoreboard_empty", 42'(exp_q.size()), 42'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/oven_display_seq.md
OVEN_DISPLAY_SEQ -- requirements
Module: oven_display_seq

Interface
REQ-001 Parameter TEMP_W, default 10: width of the temperature inputs, in degrees.
REQ-002 Parameter TIME_W, default 13: width of the time inputs, in seconds.
REQ-003 Parameter REFRESH_DIV, default 50000: clock cycles per conversion pass; legal range is 256 or more.
REQ-004 Parameter BLINK_DIV, default 25000000: clock cycles per blink-phase toggle; legal range is 1 or more.
REQ-005 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Ports power, tempInputDone and timeInputDone, inputs, 1 bit each: oven mode controls.
REQ-008 Ports current_temp and target_temp, inputs, TEMP_W bits each: binary degrees.
REQ-009 Ports current_time and target_time, inputs, TIME_W bits each: binary seconds.
REQ-010 Ports hex0 to hex5, outputs, 7 bits each, declared [0:6]: active-low segments, index 0 = segment a through index 6 = segment g, registered; hex0 is the rightmost digit.
REQ-011 Port busy, output, 1 bit: registered; high while a conversion pass is in progress.

Function
REQ-012 Refresh counter shall count 0 to REFRESH_DIV-1 and wrap; the wrap cycle is the refresh tick.
REQ-013 FSM states IDLE, SNAP, SPLIT, BCD, COMMIT; transitions:
- IDLE to SNAP on refresh tick.
- SNAP to SPLIT, then SPLIT to BCD, then BCD to COMMIT, then COMMIT to IDLE.
REQ-014 In SNAP the block shall capture all data inputs and the mode into registers; input changes after SNAP shall not affect that pass.
REQ-015 Mode decode:
- OFF: power=0; show current_time.
- TSET: power=1, tempInputDone=0; show target_temp.
- MSET: power=1, tempInputDone=1, timeInputDone=0; show target_time.
- RUN: all three inputs high; show current_temp on hex2..hex0 and target_temp on hex5..hex3.
REQ-016 SPLIT shall derive minutes and seconds by subtracting 60 once per cycle.
- Minutes shall saturate at 99, which forces seconds to 59.
- Temperatures shall saturate at 999.
REQ-017 BCD shall use shift-add-3 (double dabble), one bit per cycle per operand; operands convert in parallel.
REQ-018 Total pass latency, SNAP through COMMIT, shall be at most 200 cycles; busy shall be high from SNAP through COMMIT inclusive.
REQ-019 COMMIT shall update hex0 to hex5 in the same cycle, so no partial display is ever visible.
REQ-020 Time layout (OFF and MSET):
- hex4/hex3: minutes, tens/ones.
- hex2: dash, 1111110.
- hex1/hex0: seconds, tens/ones.
- hex5: blank, 1111111.
REQ-021 TSET layout: hex2..hex0 show the temperature; hex5..hex3 are blank.
REQ-022 Digit encodings, index order a to g:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
REQ-023 The blink counter shall toggle the blink phase every BLINK_DIV cycles.
- In TSET and MSET, digit outputs shall be blank while the phase is 1.
- The dash shall never blink.
- OFF and RUN shall never blink.
REQ-024 Blink gating shall apply combinationally to the committed digits at the output register, so blinking does not wait for a refresh.
REQ-025 A mode change during a pass shall take effect at the next refresh tick; a change coinciding with the refresh tick shall be captured.

Reset
REQ-026 While reset is high:
- hex0 to hex5 = 1111111.
- busy = 0.
- FSM in IDLE.
- Refresh counter, blink counter and blink phase = 0.
REQ-027 Reset mid-pass shall abort the pass without committing.
REQ-028 The first pass after reset release shall start at the first refresh tick.

Configuration
REQ-029 Macro OVEN_DISP_LEADING_ZERO_BLANK_EN:
- Defined: leading-zero hundreds and tens digits of every temperature field are blanked; the ones digit is always shown; time fields are never blanked.
- Undefined: all digits are shown, including zeros.

Verification
REQ-030 Bench parameters: REFRESH_DIV=256, BLINK_DIV=1000.
REQ-031 Scenario 1: power=0, current_time=754 -> after a pass, hex4..hex0 = 1,2,dash,3,4; hex5 blank.
REQ-032 Scenario 2: RUN, current_temp=75, target_temp=350, macro defined -> hex5..hex3 = 3,5,0 and hex2..hex0 = blank,7,5; with the macro undefined, hex2 = 0.
REQ-033 Scenario 3: MSET, target_time=8191 -> shows 99-59; digits blank for 1000 cycles, then shown for 1000 cycles, alternating; the dash is steady.
REQ-034 Scenario 4: change target_temp from 200 to 450 one cycle after SNAP -> display stays 200 for that pass, shows 450 after the next pass; busy never exceeds 200 cycles.
REQ-035 Scenario 5: assert reset mid-BCD -> all hex outputs 1111111 and busy 0 immediately (asynchronous); no commit occurs; the first pass after release restores the digits.
